// File: rtl/gtrg_hdr_fmt.sv
// GTRG FIFO consumer: pops one trigger entry per event, tags it with an L1A number,
// and serialises four DMB header words over a valid/acknowledge handshake.
module gtrg_hdr_fmt #(
    parameter int TMR = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        L1ARST,
    input  logic        EMPTY_B,
    input  logic [16:0] DAVSOUT,
    input  logic [11:0] BXCOUNTOUT,
    input  logic [3:0]  CFEBBX,
    output logic        POP,
    output logic [15:0] HDR_DATA,
    output logic        HDR_DV,
    input  logic        HDR_ACK,
    output logic [4:0]  RDMASK,
    output logic [4:0]  MISMATCH,
    output logic        RDSTRB,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic        capt;

    logic [16:0] hold_dav;
    logic [11:0] hold_bx;
    logic [3:0]  hold_cb;
    logic [11:0] ev_num;
    logic [11:0] cnt;
    logic [11:0] cnt_base;
    logic [15:0] word;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_IDLE: if (EN && EMPTY_B) state_next = S_WAIT;
            S_WAIT: state_next = S_CAPT;
            S_CAPT: begin
                state_next = S_SEND;
                idx_next   = '0;
            end
            S_SEND: if (HDR_ACK) begin
                idx_next = idx + 2'd1;
                if (idx == 2'd3) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state optionally held in three copies; bitwise majority masks a single upset.
    generate
        if (TMR != 0) begin : g_tmr
            state_t     st_q  [3];
            logic [1:0] idx_q [3];
            always_ff @(posedge CLK) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    if (RST) begin
                        st_q[i]  <= S_IDLE;
                        idx_q[i] <= '0;
                    end else begin
                        st_q[i]  <= state_next;
                        idx_q[i] <= idx_next;
                    end
                end
            end
            assign state = state_t'((st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]));
            assign idx   = (idx_q[0] & idx_q[1]) | (idx_q[0] & idx_q[2]) | (idx_q[1] & idx_q[2]);
        end else begin : g_plain
            state_t     st_q;
            logic [1:0] idx_q;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    st_q  <= S_IDLE;
                    idx_q <= '0;
                end else begin
                    st_q  <= state_next;
                    idx_q <= idx_next;
                end
            end
            assign state = st_q;
            assign idx   = idx_q;
        end
    endgenerate

    assign capt     = (state == S_CAPT);
    assign cnt_base = L1ARST ? 12'd0 : cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_dav <= '0;
            hold_bx  <= '0;
            hold_cb  <= '0;
            ev_num   <= '0;
            cnt      <= '0;
            RDMASK   <= '0;
            MISMATCH <= '0;
            RDSTRB   <= 1'b0;
        end else begin
            RDSTRB <= capt;
            cnt    <= cnt_base + {11'd0, capt};
            if (capt) begin
                hold_dav <= DAVSOUT;
                hold_bx  <= BXCOUNTOUT;
                hold_cb  <= CFEBBX;
                ev_num   <= cnt_base;
                RDMASK   <= DAVSOUT[5:1] | DAVSOUT[15:11];
                MISMATCH <= DAVSOUT[5:1] ^ DAVSOUT[15:11];
            end
        end
    end

    always_comb begin
        word = '0;
        case (idx)
            2'd0: word = {4'h9, ev_num};
            2'd1: word = {4'hA, hold_bx};
            2'd2: word = {4'hB, hold_cb, hold_dav[16], hold_dav[0], hold_dav[5:1], 1'b0};
            2'd3: word = {4'hC, 2'b00, hold_dav[10:6], hold_dav[15:11]};
            default: word = '0;
        endcase
    end

    assign POP      = capt;
    assign HDR_DV   = (state == S_SEND);
    assign HDR_DATA = HDR_DV ? word : 16'h0000;
    assign BUSY     = (state != S_IDLE);

endmodule

// File: tb/tb_gtrg_hdr_fmt.sv
// Bench for gtrg_hdr_fmt: fixed vector table, hand sequences for corner cases,
// and a long randomized run checked against an arithmetic field model.
module tb_gtrg_hdr_fmt;

    logic        CLK = 1'b0;
    logic        RST, EN, L1ARST, EMPTY_B, HDR_ACK;
    logic [16:0] DAVSOUT;
    logic [11:0] BXCOUNTOUT;
    logic [3:0]  CFEBBX;
    logic        POP, HDR_DV, RDSTRB, BUSY;
    logic [15:0] HDR_DATA;
    logic [4:0]  RDMASK, MISMATCH;

    gtrg_hdr_fmt #(.TMR(0)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .L1ARST(L1ARST), .EMPTY_B(EMPTY_B),
        .DAVSOUT(DAVSOUT), .BXCOUNTOUT(BXCOUNTOUT), .CFEBBX(CFEBBX),
        .POP(POP), .HDR_DATA(HDR_DATA), .HDR_DV(HDR_DV), .HDR_ACK(HDR_ACK),
        .RDMASK(RDMASK), .MISMATCH(MISMATCH), .RDSTRB(RDSTRB), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;
    int ev_model = 0;
    int last_pop = 0;

    typedef struct {
        logic [16:0] d;
        logic [11:0] bx;
        logic [3:0]  cb;
        logic [15:0] w1, w2, w3;
        logic [4:0]  mask, mism;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_word(input int w, input logic [16:0] d,
                                             input logic [11:0] bx, input logic [3:0] cb, input int ev);
        int dd;
        int v;
        dd = int'(d);
        case (w)
            0: v = 'h9000 + (ev % 4096);
            1: v = 'hA000 + int'(bx);
            2: v = 'hB000 + int'(cb) * 256 + ((dd >> 16) & 1) * 128 + (dd & 1) * 64 + ((dd >> 1) & 31) * 2;
            3: v = 'hC000 + ((dd >> 6) & 31) * 32 + ((dd >> 11) & 31);
            default: v = 0;
        endcase
        return v[15:0];
    endfunction

    function automatic logic [4:0] ref_mask(input logic [16:0] d);
        int dd;
        int v;
        dd = int'(d);
        v = ((dd >> 1) & 31) | ((dd >> 11) & 31);
        return v[4:0];
    endfunction

    function automatic logic [4:0] ref_mism(input logic [16:0] d);
        int dd;
        int v;
        dd = int'(d);
        v = ((dd >> 1) & 31) ^ ((dd >> 11) & 31);
        return v[4:0];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pop"}, POP, 0);
        chk({tag, "_dv"}, HDR_DV, 0);
        chk({tag, "_data"}, HDR_DATA, 0);
        chk({tag, "_rdmask"}, RDMASK, 0);
        chk({tag, "_mismatch"}, MISMATCH, 0);
        chk({tag, "_rdstrb"}, RDSTRB, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    // Starts and finishes at a falling edge with the DUT in IDLE.
    task automatic do_event(input logic [16:0] d, input logic [11:0] bx, input logic [3:0] cb,
                            input logic [15:0] w0e, input logic [15:0] w1e,
                            input logic [15:0] w2e, input logic [15:0] w3e,
                            input logic [4:0] mske, input logic [4:0] mise,
                            input int stall_word, input int stall_n,
                            input bit more, input bit l1a, input bit drop_en,
                            input int abort_word, input bit b2b);
        logic [15:0] ew [4];
        ew[0] = w0e; ew[1] = w1e; ew[2] = w2e; ew[3] = w3e;
        DAVSOUT = d; BXCOUNTOUT = bx; CFEBBX = cb;
        EMPTY_B = 1'b1; HDR_ACK = 1'b1;
        @(negedge CLK);
        chk("wait_pop", POP, 0);
        chk("wait_busy", BUSY, 1);
        @(negedge CLK);
        chk("capt_pop", POP, 1);
        chk("capt_dv", HDR_DV, 0);
        if (b2b) chk("pop_spacing", cyc - last_pop, 7);
        last_pop = cyc;
        EMPTY_B = more;
        L1ARST  = l1a;
        @(negedge CLK);
        L1ARST = 1'b0;
        chk("rdstrb", RDSTRB, 1);
        chk("rdmask", RDMASK, mske);
        chk("mismatch", MISMATCH, mise);
        for (int w = 0; w < 4; w++) begin
            if (w == 1 && drop_en) EN = 1'b0;
            if (w == abort_word) begin
                HDR_ACK = 1'b0;
                chk("abort_dv", HDR_DV, 1);
                chk("abort_data", HDR_DATA, ew[w]);
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                check_reset_outputs("abort");
                ev_model = 0;
                return;
            end
            for (int s = 0; s < ((w == stall_word) ? stall_n : 0); s++) begin
                HDR_ACK = 1'b0;
                chk("hold_dv", HDR_DV, 1);
                chk("hold_data", HDR_DATA, ew[w]);
                @(negedge CLK);
            end
            HDR_ACK = 1'b1;
            chk("send_dv", HDR_DV, 1);
            chk($sformatf("word%0d", w), HDR_DATA, ew[w]);
            chk("send_pop", POP, 0);
            if (w > 0 || stall_word == 0 && stall_n > 0) chk("rdstrb_once", RDSTRB, 0);
            @(negedge CLK);
        end
        chk("end_busy", BUSY, 0);
        chk("end_dv", HDR_DV, 0);
        ev_model = l1a ? 1 : (ev_model + 1) % 4096;
    endtask

    task automatic rnd_event(input int stall_word, input int stall_n, input bit more,
                             input bit b2b, input bit use_w0, input logic [15:0] w0c, input bit l1a);
        logic [16:0] d;
        logic [11:0] bx;
        logic [3:0]  cb;
        logic [15:0] w0;
        d  = 17'($urandom);
        bx = 12'($urandom);
        cb = 4'($urandom);
        w0 = use_w0 ? w0c : ref_word(0, d, bx, cb, ev_model);
        do_event(d, bx, cb, w0, ref_word(1, d, bx, cb, ev_model), ref_word(2, d, bx, cb, ev_model),
                 ref_word(3, d, bx, cb, ev_model), ref_mask(d), ref_mism(d),
                 stall_word, stall_n, more, l1a, 1'b0, -1, b2b);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        tbl[0] = '{17'h18421, 12'h5A3, 4'h6, 16'hA5A3, 16'hB6E0, 16'hC210, 5'h10, 5'h00};
        tbl[1] = '{17'h0003E, 12'h000, 4'hF, 16'hA000, 16'hBF3E, 16'hC000, 5'h1F, 5'h1F};
        tbl[2] = '{17'h0F800, 12'hFFF, 4'h0, 16'hAFFF, 16'hB000, 16'hC01F, 5'h1F, 5'h1F};
        tbl[3] = '{17'h107C1, 12'h123, 4'h3, 16'hA123, 16'hB3C0, 16'hC3E0, 5'h00, 5'h00};
        tbl[4] = '{17'h05A0A, 12'h7E4, 4'h9, 16'hA7E4, 16'hB90A, 16'hC10B, 5'h0F, 5'h0E};

        RST = 1'b1; EN = 1'b0; L1ARST = 1'b0; EMPTY_B = 1'b0; HDR_ACK = 1'b0;
        DAVSOUT = '0; BXCOUNTOUT = '0; CFEBBX = '0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        EN  = 1'b1;
        @(negedge CLK);

        // Entry 1 carries a 3-cycle stall on W1.
        for (int i = 0; i < 5; i++) begin
            do_event(tbl[i].d, tbl[i].bx, tbl[i].cb, 16'h9000 + 16'(ev_model), tbl[i].w1,
                     tbl[i].w2, tbl[i].w3, tbl[i].mask, tbl[i].mism,
                     (i == 1) ? 1 : -1, (i == 1) ? 3 : 0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        end

        rnd_event(-1, 0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        rnd_event(-1, 0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
        rnd_event(-1, 0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

        EN = 1'b0; EMPTY_B = 1'b1; bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (POP !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        chk("en_gate_cycles", bad, 0);
        EMPTY_B = 1'b0; EN = 1'b1;
        @(negedge CLK);

        do_event(tbl[4].d, tbl[4].bx, tbl[4].cb, 16'h9000 + 16'(ev_model), tbl[4].w1,
                 tbl[4].w2, tbl[4].w3, tbl[4].mask, tbl[4].mism, -1, 0, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (POP !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        chk("en_drop_cycles", bad, 0);
        EMPTY_B = 1'b0; EN = 1'b1;
        @(negedge CLK);

        do_event(tbl[0].d, tbl[0].bx, tbl[0].cb, 16'h9000 + 16'(ev_model), tbl[0].w1,
                 tbl[0].w2, tbl[0].w3, tbl[0].mask, tbl[0].mism, -1, 0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        @(negedge CLK);
        rnd_event(-1, 0, 1'b0, 1'b0, 1'b1, 16'h9000, 1'b0);

        for (int k = 0; k < 5000 && ev_model != 4095; k++) begin
            if (k < 64) rnd_event($urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            else        rnd_event(-1, 0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        end

        rnd_event(-1, 0, 1'b0, 1'b0, 1'b1, 16'h9FFF, 1'b0);
        rnd_event(-1, 0, 1'b0, 1'b0, 1'b1, 16'h9000, 1'b0);
        rnd_event(-1, 0, 1'b0, 1'b0, 1'b1, 16'h9000, 1'b1);
        rnd_event(-1, 0, 1'b0, 1'b0, 1'b1, 16'h9001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
